// File: rtl/cmult_pkg.sv
// Shared types for the conditional multiplier pipeline: per-sample mode and stage control.
package cmult_pkg;

  typedef enum logic [1:0] {
    CM_BYPASS = 2'b00,
    CM_MULT   = 2'b01,
    CM_SCALED = 2'b10,
    CM_ZERO   = 2'b11
  } cmult_mode_e;

  // Control carried alongside each stage's product; dataa travels in a parallel
  // array because its width is a module parameter.
  typedef struct packed {
    logic        valid;
    cmult_mode_e mode;
  } cmult_stage_t;

endpackage

// File: rtl/conditional_mult_pipe_round_sat.sv
// Combinational round-half-up, shift and clip of a full-width product to A_WIDTH,
// re-extended to OUT_WIDTH.
module round_sat #(
  parameter int OUT_WIDTH = 32,
  parameter int A_WIDTH   = 16,
  parameter int FRAC_BITS = 15,
  parameter int SIGNED    = 1
) (
  input  logic [OUT_WIDTH-1:0] product,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 sat
);

  localparam int RW = OUT_WIDTH + 1;
  localparam logic [RW-1:0] HALF = RW'(1) << (FRAC_BITS - 1);

  logic [RW-1:0]      ext;
  logic [RW-1:0]      sum;
  logic [RW-1:0]      r;
  logic [A_WIDTH-1:0] clip;

  always_comb begin
    // One guard bit keeps the rounding add from wrapping.
    ext = {(SIGNED != 0) && product[OUT_WIDTH-1], product};
    sum = ext + HALF;
    if (SIGNED != 0) begin
      r   = $signed(sum) >>> FRAC_BITS;
      sat = !((&r[RW-1:A_WIDTH-1]) || !(|r[RW-1:A_WIDTH-1]));
      if (!sat)
        clip = r[A_WIDTH-1:0];
      else if (r[RW-1])
        clip = {1'b1, {(A_WIDTH-1){1'b0}}};
      else
        clip = {1'b0, {(A_WIDTH-1){1'b1}}};
      result = {{(OUT_WIDTH-A_WIDTH){clip[A_WIDTH-1]}}, clip};
    end else begin
      r      = sum >> FRAC_BITS;
      sat    = |r[RW-1:A_WIDTH];
      clip   = sat ? '1 : r[A_WIDTH-1:0];
      result = {{(OUT_WIDTH-A_WIDTH){1'b0}}, clip};
    end
  end

endmodule

// File: rtl/conditional_mult_pipe.sv
// Global-stall pipelined multiplier with per-sample bypass/product/scaled/zero modes
// and valid/ready flow control.
module conditional_mult_pipe
  import cmult_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int LATENCY   = 3,
  parameter int FRAC_BITS = 15,
  parameter int SIGNED    = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 mode,
  input  logic [A_WIDTH-1:0]         dataa,
  input  logic [B_WIDTH-1:0]         datab,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] result,
  output logic                       sat_flag
);

  localparam int OUT_WIDTH = A_WIDTH + B_WIDTH;

  logic                 advance;
  cmult_stage_t         head_ctl;
  cmult_stage_t         tail_ctl;
  logic [A_WIDTH-1:0]   tail_a;
  logic [OUT_WIDTH-1:0] a_ext;
  logic [OUT_WIDTH-1:0] b_ext;
  logic [OUT_WIDTH-1:0] head_prod;
  logic [OUT_WIDTH-1:0] tail_prod;
  logic [OUT_WIDTH-1:0] scaled_res;
  logic [OUT_WIDTH-1:0] bypass_res;
  logic                 scaled_sat;

  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] result_q, result_d;
  logic                 sat_q, sat_d;

  assign advance  = !(out_valid_q && !out_ready);
  assign in_ready = advance;

  always_comb begin
    head_ctl.valid = in_valid;
    head_ctl.mode  = cmult_mode_e'(mode);
    a_ext = (SIGNED != 0) ? {{B_WIDTH{dataa[A_WIDTH-1]}}, dataa} : {{B_WIDTH{1'b0}}, dataa};
    b_ext = (SIGNED != 0) ? {{A_WIDTH{datab[B_WIDTH-1]}}, datab} : {{A_WIDTH{1'b0}}, datab};
    head_prod = a_ext * b_ext;
  end

  // The output register is the last of the LATENCY stages; the rest carry the
  // product so synthesis can retime the multiplier across them.
  if (LATENCY == 1) begin : g_direct
    assign tail_ctl  = head_ctl;
    assign tail_a    = dataa;
    assign tail_prod = head_prod;
  end else begin : g_stages
    localparam int NREG = LATENCY - 1;

    cmult_stage_t         ctl_q  [NREG];
    cmult_stage_t         ctl_d  [NREG];
    logic [A_WIDTH-1:0]   a_q    [NREG];
    logic [A_WIDTH-1:0]   a_d    [NREG];
    logic [OUT_WIDTH-1:0] prod_q [NREG];
    logic [OUT_WIDTH-1:0] prod_d [NREG];

    always_comb begin
      ctl_d  = ctl_q;
      a_d    = a_q;
      prod_d = prod_q;
      if (advance) begin
        ctl_d[0]  = head_ctl;
        a_d[0]    = dataa;
        prod_d[0] = head_prod;
        for (int unsigned i = 1; i < NREG; i++) begin
          ctl_d[i]  = ctl_q[i-1];
          a_d[i]    = a_q[i-1];
          prod_d[i] = prod_q[i-1];
        end
      end
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        for (int unsigned i = 0; i < NREG; i++) begin
          ctl_q[i]  <= '0;
          a_q[i]    <= '0;
          prod_q[i] <= '0;
        end
      end else begin
        ctl_q  <= ctl_d;
        a_q    <= a_d;
        prod_q <= prod_d;
      end
    end

    assign tail_ctl  = ctl_q[NREG-1];
    assign tail_a    = a_q[NREG-1];
    assign tail_prod = prod_q[NREG-1];
  end

  round_sat #(
    .OUT_WIDTH (OUT_WIDTH),
    .A_WIDTH   (A_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .SIGNED    (SIGNED)
  ) u_round_sat (
    .product (tail_prod),
    .result  (scaled_res),
    .sat     (scaled_sat)
  );

  always_comb begin
    bypass_res  = (SIGNED != 0) ? {{B_WIDTH{tail_a[A_WIDTH-1]}}, tail_a}
                                : {{B_WIDTH{1'b0}}, tail_a};
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sat_d       = sat_q;
    if (advance) begin
      out_valid_d = tail_ctl.valid;
      // Bubbles leave result/sat_flag holding the last delivered sample.
      if (tail_ctl.valid) begin
        case (tail_ctl.mode)
          CM_BYPASS: begin result_d = bypass_res; sat_d = 1'b0;       end
          CM_MULT:   begin result_d = tail_prod;  sat_d = 1'b0;       end
          CM_SCALED: begin result_d = scaled_res; sat_d = scaled_sat; end
          default:   begin result_d = '0;         sat_d = 1'b0;       end
        endcase
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_conditional_mult_pipe.sv
// Directed bench for conditional_mult_pipe: signed default instance plus an unsigned twin.
module tb_conditional_mult_pipe;

  logic        Clk;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [15:0] dataa;
  logic [15:0] datab;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        sat_flag;

  logic        u_in_ready;
  logic        u_out_valid;
  logic [31:0] u_result;
  logic        u_sat_flag;

  int checks = 0;
  int errors = 0;

  conditional_mult_pipe #(
    .A_WIDTH(16), .B_WIDTH(16), .LATENCY(3), .FRAC_BITS(15), .SIGNED(1)
  ) u_dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .dataa(dataa), .datab(datab), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .sat_flag(sat_flag)
  );

  conditional_mult_pipe #(
    .A_WIDTH(16), .B_WIDTH(16), .LATENCY(3), .FRAC_BITS(15), .SIGNED(0)
  ) u_dut_u (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(u_in_ready),
    .mode(mode), .dataa(dataa), .datab(datab), .out_valid(u_out_valid),
    .out_ready(out_ready), .result(u_result), .sat_flag(u_sat_flag)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  // One isolated sample: checks acceptance, latency edge and both instances' results.
  task automatic vec(input string tag, input logic [1:0] m, input logic [15:0] a,
                     input logic [15:0] b, input logic [31:0] er, input logic es,
                     input logic [31:0] eu, input logic eus);
    mode = m; dataa = a; datab = b; in_valid = 1'b1;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    step;
    in_valid = 1'b0;
    step;
    check({tag, " early"}, 32'(out_valid), 32'd0);
    step;
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " result"}, result, er);
    check({tag, " sat"}, 32'(sat_flag), 32'(es));
    check({tag, " u_out_valid"}, 32'(u_out_valid), 32'd1);
    check({tag, " u_result"}, u_result, eu);
    check({tag, " u_sat"}, 32'(u_sat_flag), 32'(eus));
    step;
  endtask

  initial begin
    int  sent;
    int  recv;
    logic exp_ready;
    logic exp_ov;

    Reset = 1'b1; in_valid = 1'b0; mode = 2'b00; dataa = '0; datab = '0; out_ready = 1'b1;
    step;
    step;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", result, 32'd0);
    check("rst sat", 32'(sat_flag), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst u_out_valid", 32'(u_out_valid), 32'd0);
    check("rst u_in_ready", 32'(u_in_ready), 32'd1);
    Reset = 1'b0;
    step;

    vec("bypass",   2'b00, 16'h8001, 16'h0000, 32'hFFFF8001, 1'b0, 32'h00008001, 1'b0);
    vec("mult",     2'b01, 16'hFFFF, 16'h0002, 32'hFFFFFFFE, 1'b0, 32'h0001FFFE, 1'b0);
    vec("sc_half",  2'b10, 16'h4000, 16'h4000, 32'h00002000, 1'b0, 32'h00002000, 1'b0);
    vec("sc_rnd",   2'b10, 16'h0001, 16'h4000, 32'h00000001, 1'b0, 32'h00000001, 1'b0);
    vec("sc_sat",   2'b10, 16'h8000, 16'h8000, 32'h00007FFF, 1'b1, 32'h00008000, 1'b0);
    vec("sc_neg",   2'b10, 16'h8000, 16'h7FFF, 32'hFFFF8001, 1'b0, 32'h00007FFF, 1'b0);
    vec("sc_negrn", 2'b10, 16'hFFFF, 16'h4000, 32'h00000000, 1'b0, 32'h00008000, 1'b0);
    vec("sc_usat",  2'b10, 16'hFFFF, 16'hFFFF, 32'h00000000, 1'b0, 32'h0000FFFF, 1'b1);
    vec("zero",     2'b11, 16'h1234, 16'h5678, 32'h00000000, 1'b0, 32'h00000000, 1'b0);

    // Mixed modes back-to-back.
    in_valid = 1'b1; mode = 2'b01; dataa = 16'd3; datab = 16'd5;
    step;
    mode = 2'b00; dataa = 16'd7; datab = 16'd0;
    step;
    mode = 2'b11; dataa = 16'd9; datab = 16'd9;
    step;
    in_valid = 1'b0;
    check("mix0 valid", 32'(out_valid), 32'd1);
    check("mix0 result", result, 32'd15);
    step;
    check("mix1 valid", 32'(out_valid), 32'd1);
    check("mix1 result", result, 32'd7);
    step;
    check("mix2 valid", 32'(out_valid), 32'd1);
    check("mix2 result", result, 32'd0);
    step;
    check("mix drain", 32'(out_valid), 32'd0);

    // Backpressure: six products of 10, downstream stalls on cycles 4..7.
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      if (sent < 6) begin
        in_valid = 1'b1; mode = 2'b01; dataa = 16'(sent + 1); datab = 16'd10;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_ready = (cyc < 4 || cyc > 7);
      exp_ov    = (cyc >= 3 && cyc <= 12);
      check($sformatf("bp%0d in_ready", cyc), 32'(in_ready), 32'(exp_ready));
      check($sformatf("bp%0d out_valid", cyc), 32'(out_valid), 32'(exp_ov));
      if (exp_ov)
        check($sformatf("bp%0d result", cyc), result, 32'(10 * (recv + 1)));
      if (exp_ov && out_ready) recv++;
      if (exp_ready && sent < 6) sent++;
      step;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;

    // Reset with two samples in flight.
    in_valid = 1'b1; mode = 2'b01; dataa = 16'd2; datab = 16'd3;
    step;
    mode = 2'b00; dataa = 16'h0055; datab = 16'd0;
    step;
    in_valid = 1'b0;
    check("pre-rst held result", result, 32'd60);
    #3;
    Reset = 1'b1;
    #1;
    check("mid-rst out_valid", 32'(out_valid), 32'd0);
    check("mid-rst result", result, 32'd0);
    step;
    Reset = 1'b0;
    in_valid = 1'b1; mode = 2'b01; dataa = 16'd4; datab = 16'd4;
    step;
    in_valid = 1'b0;
    check("post-rst c1", 32'(out_valid), 32'd0);
    step;
    check("post-rst c2", 32'(out_valid), 32'd0);
    step;
    check("post-rst c3 valid", 32'(out_valid), 32'd1);
    check("post-rst c3 result", result, 32'd16);
    step;
    check("post-rst c4", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
